// File: rtl/multi_chan_counter_if.sv
// Snapshot read port of the multi-channel counter bank.
// The requester drives rd_req/rd_ch/rd_ready and the counter bank returns rd_valid/rd_data/rd_err.
interface multi_chan_counter_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_CH = 4
);
    localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             rd_req;
    logic [CHW-1:0]   rd_ch;
    logic             rd_ready;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             rd_err;

    modport master (
        output rd_req, rd_ch, rd_ready,
        input  rd_valid, rd_data, rd_err
    );

    modport slave (
        input  rd_req, rd_ch, rd_ready,
        output rd_valid, rd_data, rd_err
    );
endinterface

// File: rtl/multi_chan_counter.sv
// N-channel enable-driven counter bank with clear/load, wrap or saturate mode,
// terminal-count pulses and a registered valid/ready snapshot read port.
module multi_chan_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned SAT_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        en,
    input  logic [NUM_CH-1:0]        clr,
    input  logic [NUM_CH-1:0]        ld,
    input  logic [NUM_CH*WIDTH-1:0]  ld_val,
    output logic [NUM_CH*WIDTH-1:0]  cnt,
    output logic [NUM_CH-1:0]        tc,
    multi_chan_counter_if.slave      rd
);
    localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [WIDTH-1:0] CNT_MAX_M1 = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [NUM_CH-1:0][WIDTH-1:0] cnt_q;
    logic [NUM_CH-1:0][WIDTH-1:0] cnt_d;
    logic [NUM_CH-1:0]            tc_q;
    logic [NUM_CH-1:0]            tc_d;

    logic             rd_valid_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_err_q;
    logic             rd_accept;
    logic [WIDTH-1:0] rd_sel;
    logic             rd_hit;

    // Per-channel next value: clr > ld > en > hold; tc only from an increment.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (clr[i]) begin
                cnt_d[i] = '0;
            end else if (ld[i]) begin
                cnt_d[i] = ld_val[i*WIDTH +: WIDTH];
            end else if (en[i]) begin
                if (SAT_MODE != 0) begin
                    if (cnt_q[i] != CNT_MAX) begin
                        cnt_d[i] = cnt_q[i] + WIDTH'(1);
                        tc_d[i]  = (cnt_q[i] == CNT_MAX_M1);
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                    tc_d[i]  = (cnt_q[i] == CNT_MAX);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tc_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    // Snapshot mux over the pre-update counters; an unmatched rd_ch reads 0 with error.
    always_comb begin
        rd_sel = '0;
        rd_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rd.rd_ch == CHW'(i)) begin
                rd_sel = cnt_q[i];
                rd_hit = 1'b1;
            end
        end
    end

    assign rd_accept = rd.rd_req && (!rd_valid_q || rd.rd_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
        end else if (rd_accept) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= rd_sel;
            rd_err_q   <= !rd_hit;
        end else if (rd_valid_q && rd.rd_ready) begin
            rd_valid_q <= 1'b0;
        end
    end

    assign cnt         = cnt_q;
    assign tc          = tc_q;
    assign rd.rd_valid = rd_valid_q;
    assign rd.rd_data  = rd_data_q;
    assign rd.rd_err   = rd_err_q;

endmodule

// File: tb/tb_multi_chan_counter.sv
// Directed bench for multi_chan_counter: a wrap-mode 4-channel bank and a saturating
// 3-channel bank; read responses are checked by per-bank scoreboard monitors.
module tb_multi_chan_counter;
    logic clk;
    logic rst_n;

    logic [3:0]  en_a, clr_a, ld_a, tc_a;
    logic [31:0] ldv_a, cnt_a;
    logic [2:0]  en_b, clr_b, ld_b, tc_b;
    logic [23:0] ldv_b, cnt_b;

    multi_chan_counter_if #(.WIDTH(8), .NUM_CH(4)) ifa ();
    multi_chan_counter_if #(.WIDTH(8), .NUM_CH(3)) ifb ();

    multi_chan_counter #(.WIDTH(8), .NUM_CH(4), .SAT_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .clr(clr_a), .ld(ld_a),
        .ld_val(ldv_a), .cnt(cnt_a), .tc(tc_a), .rd(ifa)
    );

    multi_chan_counter #(.WIDTH(8), .NUM_CH(3), .SAT_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .clr(clr_b), .ld(ld_b),
        .ld_val(ldv_b), .cnt(cnt_b), .tc(tc_b), .rd(ifb)
    );

    int checks   = 0;
    int failures = 0;

    // Expected read responses, {err, data}
    logic [8:0] qa[$];
    logic [8:0] qb[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && ifa.rd_valid && ifa.rd_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_rsp", 32'(ifa.rd_data), 32'hDEAD);
            end else begin
                logic [8:0] e;
                e = qa.pop_front();
                chk("a_rd_data", 32'(ifa.rd_data), 32'(e[7:0]));
                chk("a_rd_err", 32'(ifa.rd_err), 32'(e[8]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ifb.rd_valid && ifb.rd_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_rsp", 32'(ifb.rd_data), 32'hDEAD);
            end else begin
                logic [8:0] e;
                e = qb.pop_front();
                chk("b_rd_data", 32'(ifb.rd_data), 32'(e[7:0]));
                chk("b_rd_err", 32'(ifb.rd_err), 32'(e[8]));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        en_a = '0; clr_a = '0; ld_a = '0; ldv_a = '0;
        en_b = '0; clr_b = '0; ld_b = '0; ldv_b = '0;
        ifa.rd_req = 1'b0; ifa.rd_ch = '0; ifa.rd_ready = 1'b0;
        ifb.rd_req = 1'b0; ifb.rd_ch = '0; ifb.rd_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt_a", cnt_a, 32'h0);
        chk("rst_tc_a", 32'(tc_a), 32'h0);
        chk("rst_valid_a", 32'(ifa.rd_valid), 32'h0);
        chk("rst_cnt_b", 32'(cnt_b), 32'h0);
        rst_n = 1'b1;

        // Wrap through max on ch0
        ld_a = 4'b0001; ldv_a = 32'h0000_00FE;
        step();
        chk("t1_ld", 32'(cnt_a[7:0]), 32'hFE);
        ld_a = '0; en_a = 4'b0001;
        step();
        chk("t1_cnt_ff", 32'(cnt_a[7:0]), 32'hFF);
        chk("t1_tc_ff", 32'(tc_a[0]), 32'h0);
        step();
        chk("t1_cnt_00", 32'(cnt_a[7:0]), 32'h00);
        chk("t1_tc_00", 32'(tc_a[0]), 32'h1);
        step();
        chk("t1_cnt_01", 32'(cnt_a[7:0]), 32'h01);
        chk("t1_tc_01", 32'(tc_a[0]), 32'h0);
        chk("t1_others", 32'(cnt_a[31:8]), 32'h0);
        en_a = '0;

        // Priority on ch2
        ld_a = 4'b0100; ldv_a = 32'h0033_0000;
        step();
        chk("t3_pre", 32'(cnt_a[23:16]), 32'h33);
        clr_a = 4'b0100; ld_a = 4'b0100; en_a = 4'b0100; ldv_a = 32'h0055_0000;
        step();
        chk("t3_clr_wins", 32'(cnt_a[23:16]), 32'h00);
        clr_a = '0;
        step();
        chk("t3_ld_wins", 32'(cnt_a[23:16]), 32'h55);
        en_a = '0; ldv_a = 32'h00FF_0000;
        step();
        chk("t3_ld_ff", 32'(cnt_a[23:16]), 32'hFF);
        chk("t3_ld_no_tc", 32'(tc_a), 32'h0);
        ld_a = '0; en_a = 4'b0100;
        step();
        chk("t3_wrap", 32'(cnt_a[23:16]), 32'h00);
        chk("t3_wrap_tc", 32'(tc_a), 32'h4);
        en_a = '0;

        // Snapshot read of ch3 while it counts, with a stalled consumer
        ld_a = 4'b1000; ldv_a = 32'h1000_0000;
        step();
        ld_a = '0; en_a = 4'b1000;
        ifa.rd_req = 1'b1; ifa.rd_ch = 2'd3; ifa.rd_ready = 1'b0;
        qa.push_back({1'b0, 8'h10});
        step();
        chk("t4_valid", 32'(ifa.rd_valid), 32'h1);
        chk("t4_data", 32'(ifa.rd_data), 32'h10);
        chk("t4_cnt_moved", 32'(cnt_a[31:24]), 32'h11);
        ifa.rd_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_hold_valid", 32'(ifa.rd_valid), 32'h1);
            chk("t4_hold_data", 32'(ifa.rd_data), 32'h10);
        end
        ifa.rd_ready = 1'b1;
        step();
        chk("t4_drop", 32'(ifa.rd_valid), 32'h0);
        chk("t4_cnt3", 32'(cnt_a[31:24]), 32'h15);
        ifa.rd_ready = 1'b0; en_a = '0;

        // Saturating bank: ch1 from FD
        ld_b = 3'b010; ldv_b = 24'h00_FD_00;
        step();
        ld_b = '0; en_b = 3'b010;
        step();
        chk("t2_fe", 32'(cnt_b[15:8]), 32'hFE);
        chk("t2_tc_fe", 32'(tc_b), 32'h0);
        step();
        chk("t2_ff", 32'(cnt_b[15:8]), 32'hFF);
        chk("t2_tc_ff", 32'(tc_b), 32'h2);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t2_sat", 32'(cnt_b[15:8]), 32'hFF);
            chk("t2_sat_tc", 32'(tc_b), 32'h0);
        end
        en_b = '0;

        // Out-of-range channel then back-to-back reads
        ifb.rd_req = 1'b1; ifb.rd_ch = 2'd3; ifb.rd_ready = 1'b1;
        qb.push_back({1'b1, 8'h00});
        step();
        chk("t5_err_valid", 32'(ifb.rd_valid), 32'h1);
        chk("t5_err", 32'(ifb.rd_err), 32'h1);
        ifb.rd_ch = 2'd0;
        qb.push_back({1'b0, 8'h00});
        step();
        chk("t5_b2b_valid0", 32'(ifb.rd_valid), 32'h1);
        ifb.rd_ch = 2'd1;
        qb.push_back({1'b0, 8'hFF});
        step();
        chk("t5_b2b_valid1", 32'(ifb.rd_valid), 32'h1);
        chk("t5_b2b_data1", 32'(ifb.rd_data), 32'hFF);
        ifb.rd_req = 1'b0;
        step();
        chk("t5_drop", 32'(ifb.rd_valid), 32'h0);
        ifb.rd_ready = 1'b0;

        // Async reset mid-count with a pending response
        en_a = 4'b1111;
        ifa.rd_req = 1'b1; ifa.rd_ch = 2'd0; ifa.rd_ready = 1'b0;
        qa.push_back({1'b0, 8'h01});
        step();
        ifa.rd_req = 1'b0;
        step();
        chk("t6_pending", 32'(ifa.rd_valid), 32'h1);
        #3;
        rst_n = 1'b0;
        qa.delete();
        #1;
        chk("t6_cnt_a", cnt_a, 32'h0);
        chk("t6_tc_a", 32'(tc_a), 32'h0);
        chk("t6_valid_a", 32'(ifa.rd_valid), 32'h0);
        chk("t6_data_a", 32'(ifa.rd_data), 32'h0);
        chk("t6_data_b", 32'(ifb.rd_data), 32'h0);
        chk("t6_err_b", 32'(ifb.rd_err), 32'h0);
        chk("t6_cnt_b", 32'(cnt_b), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("t6_resume", cnt_a, 32'h0101_0101);
        chk("t6_resume_valid", 32'(ifa.rd_valid), 32'h0);
        en_a = '0;
        step();

        chk("qa_drained", 32'(qa.size()), 32'h0);
        chk("qb_drained", 32'(qb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
